// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared FSM state type and T-vector helper for the TFF counter
package tff_pkg;

   localparam int TFF_MAX_W = 16;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   // Toggle mask that moves count one step; wraps MAX<->0 by toggling exactly the set bits.
   function automatic logic [TFF_MAX_W-1:0] next_t(input logic [TFF_MAX_W-1:0] count,
                                                    input logic                 up,
                                                    input logic [TFF_MAX_W-1:0] max);
      logic [TFF_MAX_W-1:0] t;
      logic                 carry;
      t     = '0;
      carry = 1'b1;
      if (up && (count == max)) begin
         t = count;
      end else if (!up && (count == '0)) begin
         t = max;
      end else begin
         for (int i = 0; i < TFF_MAX_W; i++) begin
            t[i]  = carry;
            carry = carry & (up ? count[i] : ~count[i]);
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with sync reset > preset > toggle
module tff_cell (
   input  logic Clock,
   input  logic reset,
   input  logic preset,
   input  logic T,
   output logic Q
);

   logic q_q;

   always_ff @(posedge Clock) begin
      if (reset) begin
         q_q <= 1'b0;
      end else if (preset) begin
         q_q <= 1'b1;
      end else if (T) begin
         q_q <= ~q_q;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// rtl/tff_counter_ctrl.sv - start/stop FSM and per-cell T/preset/reset decode
// driving a bank of T cells as a modulo-(MAX_COUNT+1) up/down counter.
module tff_counter_ctrl
   import tff_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 9
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   state_e           state_q, state_d;
   logic             busy_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] load_v;
   logic [WIDTH-1:0] cell_t, cell_preset, cell_reset;

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == ST_RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && !stop) state_d = ST_RUN;
         ST_RUN:  if (stop)           state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   assign load_v = (load_value > MAX_V) ? MAX_V : load_value;

   // Stop freezes the count in the same cycle it is seen.
   always_comb begin
      cell_t      = '0;
      cell_preset = '0;
      cell_reset  = '0;
      if (reset) begin
         cell_reset = '1;
      end else if (load) begin
         cell_reset  = ~load_v;
         cell_preset = load_v;
      end else if ((state_q == ST_RUN) && !stop) begin
         cell_t = WIDTH'(next_t(TFF_MAX_W'(count_q), up_down, TFF_MAX_W'(MAX_V)));
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .Clock  (Clock),
         .reset  (cell_reset[i]),
         .preset (cell_preset[i]),
         .T      (cell_t[i]),
         .Q      (count_q[i])
      );
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign tc    = (state_q == ST_RUN) && (up_down ? (count_q == MAX_V) : (count_q == '0));

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb/tb_tff_counter_ctrl.sv - scoreboard bench against a behavioural modulo counter
module tb_tff_counter_ctrl;

   localparam int W   = 4;
   localparam int MAX = 9;

   typedef struct {
      logic       tc;
      logic [W-1:0] cnt;
      logic       busy;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0, up_down = 1'b1;
   logic [W-1:0] load_value = '0;
   logic [W-1:0] count;
   logic         tc, busy;

   int   tests = 0, fails = 0;
   int   m_cnt = 0;
   bit   m_run = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   tff_counter_ctrl #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
      .Clock(clk), .reset(reset), .start(start), .stop(stop), .load(load),
      .load_value(load_value), .up_down(up_down), .count(count), .tc(tc), .busy(busy)
   );

   // Drive one cycle of inputs and push what the reference model predicts.
   task automatic cyc(input bit r, input bit st, input bit sp, input bit ld,
                      input int lv, input bit ud);
      exp_t e;
      @(posedge clk);
      #2;
      reset = r; start = st; stop = sp; load = ld; load_value = W'(lv); up_down = ud;
      e.tc = m_run && (ud ? (m_cnt == MAX) : (m_cnt == 0));
      if (r) begin
         m_cnt = 0;
         m_run = 1'b0;
      end else begin
         if (ld)                m_cnt = (lv > MAX) ? MAX : lv;
         else if (m_run && !sp) m_cnt = ud ? (m_cnt + 1) % (MAX + 1) : (m_cnt + MAX) % (MAX + 1);
         m_run = m_run ? !sp : (st && !sp);
      end
      e.cnt  = W'(m_cnt);
      e.busy = m_run;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         tests++;
         if (tc !== exp_q[0].tc) begin
            fails++;
            $display("FAIL tc at %0t: got %b expected %b", $time, tc, exp_q[0].tc);
         end
      end
   end

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (count !== e.cnt) begin
            fails++;
            $display("FAIL count at %0t: got %0d expected %0d", $time, count, e.cnt);
         end
         tests++;
         if (busy !== e.busy) begin
            fails++;
            $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
         end
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      // up count through a wrap, then reset while running
      cyc(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++)  cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      // down from 0
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
      // clamped load while idle, then load in run
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 15, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 7, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 1, 2, 1);
      // start+stop while idle, stop in run at 3
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      // direction flip at 9
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 5) != 0));
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
